// File: rtl/pclk_word_clk_gen_if.sv
// PIPE clock-generator signal bundle: width select in, Word_CLK/PCLK/status out.
interface pclk_word_clk_gen_if;
  logic [5:0] DataBusWidth;
  logic       Word_CLK;
  logic       PCLK;
  logic       Width_Err;
  logic       Clk_Locked;

  modport master (output DataBusWidth, input Word_CLK, PCLK, Width_Err, Clk_Locked);
  modport slave  (input DataBusWidth, output Word_CLK, PCLK, Width_Err, Clk_Locked);
endinterface

// File: rtl/pclk_word_clk_gen.sv
// Derives Word_CLK (WORD_DIV bits) and phase-aligned PCLK (R words) from Bit_CLK.
// Optional lock indication compiled in with CLKGEN_LOCK_EN; otherwise Clk_Locked is tied low.
module pclk_word_clk_gen #(
  parameter int WORD_DIV = 10
) (
  input  logic              Bit_CLK,
  input  logic              Rst_n,
  pclk_word_clk_gen_if.slave bus
);

  localparam int             CW   = $clog2(WORD_DIV);
  localparam logic [CW-1:0]  LAST = CW'(WORD_DIV - 1);
  localparam logic [CW-1:0]  HALF = CW'(WORD_DIV / 2);

  generate
    if (WORD_DIV < 4 || (WORD_DIV % 2) != 0) begin : g_param_chk
      $fatal(1, "pclk_word_clk_gen: WORD_DIV must be even and >= 4");
    end
  endgenerate

  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    ratio_q, ratio_d;
  logic          word_clk_q, word_clk_d;
  logic          pclk_q, pclk_d;
  logic          width_err_q, width_err_d;
  logic [2:0]    req_ratio;
  logic          width_ok;
  logic          word_wrap;
  logic          boundary;
  logic [31:0]   pclk_pos;
  logic [31:0]   pclk_half;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    req_ratio = 3'd1;
    width_ok  = 1'b1;
    case (bus.DataBusWidth)
      6'd8:    req_ratio = 3'd1;
      6'd16:   req_ratio = 3'd2;
      6'd32:   req_ratio = 3'd4;
      default: width_ok  = 1'b0;
    endcase
  end

  always_comb begin
    word_wrap  = (word_cnt_q == LAST);
    boundary   = word_wrap && (phase_q == 2'(ratio_q - 3'd1));
    word_cnt_d = word_wrap ? '0 : word_cnt_q + CW'(1);

    phase_d = phase_q;
    if (boundary)       phase_d = '0;
    else if (word_wrap) phase_d = phase_q + 2'd1;

    // Ratio only moves at a PCLK period boundary, so periods are never cut or stretched.
    ratio_d = ratio_q;
    if (boundary && width_ok) ratio_d = req_ratio;

    width_err_d = !width_ok;

    // Decoding next-state values makes outputs line up with the counter edge itself.
    word_clk_d = (word_cnt_d < HALF);
    pclk_pos   = 32'(phase_d) * 32'(WORD_DIV) + 32'(word_cnt_d);
    pclk_half  = 32'(ratio_d) * 32'(WORD_DIV / 2);
    pclk_d     = (pclk_pos < pclk_half);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Bit_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      word_cnt_q  <= LAST;
      phase_q     <= '0;
      ratio_q     <= 3'd1;
      word_clk_q  <= 1'b0;
      pclk_q      <= 1'b0;
      width_err_q <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      phase_q     <= phase_d;
      ratio_q     <= ratio_d;
      word_clk_q  <= word_clk_d;
      pclk_q      <= pclk_d;
      width_err_q <= width_err_d;
    end
  end

  assign bus.Word_CLK  = word_clk_q;
  assign bus.PCLK      = pclk_q;
  assign bus.Width_Err = width_err_q;

`ifdef CLKGEN_LOCK_EN
  logic seen_q;
  logic lock_q;
  logic ratio_change;

  assign ratio_change = width_ok && (req_ratio != ratio_q);

  // seen_q marks that one boundary has passed, so the next one ends a full period.
  always_ff @(posedge Bit_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      seen_q <= 1'b0;
      lock_q <= 1'b0;
    end else if (boundary) begin
      seen_q <= 1'b1;
      lock_q <= ratio_change ? 1'b0 : seen_q;
    end
  end

  assign bus.Clk_Locked = lock_q;
`else
  assign bus.Clk_Locked = 1'b0;
`endif

endmodule

// File: tb/tb_pclk_word_clk_gen.sv
// Randomized self-checking bench for pclk_word_clk_gen against an edge-timestamp model.
module tb_pclk_word_clk_gen;
  localparam int WD = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pclk_word_clk_gen_if bus ();

  pclk_word_clk_gen #(.WORD_DIV(WD)) dut (
    .Bit_CLK (clk),
    .Rst_n   (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Model: edges since reset release, edge of last PCLK period start, current ratio,
  // and the edge at which lock is due.
  int edge_n, b_last, r_cur, lock_at;

  function automatic int ratio_of(input logic [5:0] w);
    case (w)
      6'd8:    return 1;
      6'd16:   return 2;
      6'd32:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    logic [5:0] w;
    int         newr, off;
    logic       exp_lock;
    @(posedge clk);
    w    = bus.DataBusWidth;
    newr = ratio_of(w);
    edge_n++;
    if (edge_n == 1 || edge_n == b_last + r_cur * WD) begin
      b_last = edge_n;
      if (edge_n == 1) begin
        if (newr != 0) r_cur = newr;
        lock_at = 1 + r_cur * WD;
      end else if (newr != 0 && newr != r_cur) begin
        r_cur   = newr;
        lock_at = edge_n + r_cur * WD;
      end
    end
    off = edge_n - b_last;
`ifdef CLKGEN_LOCK_EN
    exp_lock = (edge_n >= lock_at);
`else
    exp_lock = 1'b0;
`endif
    #1;
    check("word_clk",   32'(bus.Word_CLK),   32'((off % WD) < WD / 2));
    check("pclk",       32'(bus.PCLK),       32'(off < r_cur * WD / 2));
    check("width_err",  32'(bus.Width_Err),  32'(newr == 0));
    check("clk_locked", 32'(bus.Clk_Locked), 32'(exp_lock));
  endtask

  task automatic do_reset(input logic [5:0] w);
    rst_n = 1'b0;
    #1;
    check("rst_word_clk",   32'(bus.Word_CLK),   32'd0);
    check("rst_pclk",       32'(bus.PCLK),       32'd0);
    check("rst_width_err",  32'(bus.Width_Err),  32'd0);
    check("rst_clk_locked", 32'(bus.Clk_Locked), 32'd0);
    bus.DataBusWidth = w;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    edge_n  = 0;
    b_last  = 0;
    r_cur   = 1;
    lock_at = 32'h7fff_ffff;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.DataBusWidth = 6'd8;
    #2;
    do_reset(6'd8);  run(40);
    do_reset(6'd16); run(60);
    do_reset(6'd32); run(100);

    // width 8 -> 32 mid-period (word_cnt=3 after edge 24)
    do_reset(6'd8);  run(24);
    bus.DataBusWidth = 6'd32;
    run(100);

    // invalid width for 30 cycles while at 16
    do_reset(6'd16); run(45);
    bus.DataBusWidth = 6'd12;
    run(30);
    bus.DataBusWidth = 6'd16;
    run(60);

    // async reset while PCLK high mid-period at width 32, then restart
    do_reset(6'd32); run(45);
    check("pre_rst_pclk_high", 32'(bus.PCLK), 32'd1);
    do_reset(6'd32); run(100);

    // random width changes, occasionally invalid
    do_reset(6'd16);
    for (int i = 0; i < 1500; i++) begin
      int r;
      step();
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        case ($urandom_range(0, 2))
          0:       bus.DataBusWidth = 6'd8;
          1:       bus.DataBusWidth = 6'd16;
          default: bus.DataBusWidth = 6'd32;
        endcase
      end else if (r < 5) begin
        bus.DataBusWidth = 6'($urandom_range(0, 63));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pclk_word_clk_gen.md
# pclk_word_clk_gen

Clock-generation block for the PHY TX/RX datapath. From the serial Bit_CLK it produces Word_CLK, one period per WORD_DIV bits, and the PIPE parallel clock PCLK, whose period depends on DataBusWidth: 8, 16 or 32 bits. All outputs are registered, 50% duty, and phase-aligned: every PCLK rising edge coincides with a Word_CLK rising edge. With WORD_DIV=10 it produces the PHY timing of 0.2 ns Bit_CLK, 2 ns Word_CLK and 2/4/8 ns PCLK.

## Interface
Parameters:
- WORD_DIV, default 10: Bit_CLK cycles per Word_CLK period. Must be even and ≥4; the RTL elaborates a $fatal if not.

Ports:
- Bit_CLK, input, 1: the single clock; rising-edge.
- Rst_n, input, 1: reset, asynchronous, active-low.
- DataBusWidth, input, 6: PIPE width select.
  - 6'd8 gives ratio R=1, 6'd16 gives R=2, 6'd32 gives R=4.
  - Any other value is invalid.
- Word_CLK, output, 1: word clock, period WORD_DIV Bit_CLK cycles.
- PCLK, output, 1: parallel clock, period R·WORD_DIV Bit_CLK cycles.
- Width_Err, output, 1: high while DataBusWidth is invalid; 1-cycle registered latency.
- Clk_Locked, output, 1: PCLK has completed one full period at the current ratio.

## Operation
- State:
  - word_cnt: 0..WORD_DIV-1.
  - phase: 0..R-1.
  - ratio register R.
  - lock flag.
- Reset (Rst_n=0, asynchronous):
  - word_cnt=WORD_DIV-1, phase=0, R=1.
  - Word_CLK=0, PCLK=0, Width_Err=0, Clk_Locked=0.
- Each Bit_CLK edge:
  - word_cnt increments, wrapping WORD_DIV-1→0.
  - On a word_cnt wrap, phase increments, wrapping R-1→0.
- Boundary: the edge where word_cnt wraps and phase wraps, i.e. the end of a PCLK period. At every boundary, R loads from DataBusWidth if valid; otherwise R is held. The new R takes effect for the period starting at that edge.
- The first edge after reset release is a boundary: word_cnt=WORD_DIV-1 and phase=R-1=0. Initial R is therefore latched there.
- DataBusWidth changes between boundaries are ignored until the next boundary. There is never a truncated or stretched PCLK period.
- Outputs are registered decodes of the next-state counters:
  - Word_CLK = (word_cnt < WORD_DIV/2).
  - PCLK = (phase·WORD_DIV + word_cnt < R·WORD_DIV/2).
- Width_Err is registered each edge from "DataBusWidth ∉ {8,16,32}", independent of boundaries.
- Invalid width present at a boundary:
  - R is held.
  - Clk_Locked is unaffected.

## Timing
- Call the first Bit_CLK rising edge after Rst_n deasserts edge 1.
- Word_CLK and PCLK both rise at edge 1.
- Word_CLK:
  - Rises at edges 1 + k·WORD_DIV.
  - Falls at 1 + WORD_DIV/2 + k·WORD_DIV.
- PCLK:
  - Rises at edges 1 + k·R·WORD_DIV.
  - Falls R·WORD_DIV/2 edges after each rise.
- Width change at boundary edge b to ratio R':
  - The next PCLK rise is at b.
  - Subsequent rises follow every R'·WORD_DIV edges.
- Clk_Locked:
  - After reset, it is 1 from edge 1 + R·WORD_DIV onward.
  - On a ratio change it drops to 0 at boundary edge b.
  - It rises again at b + R'·WORD_DIV.
  - Reloading the same R at a boundary does not drop the lock.
- Rst_n asserted mid-period: all outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- CLKGEN_LOCK_EN
  - Defined: the lock flag and Clk_Locked behave as specified above.
  - Undefined: the lock logic is not compiled, and Clk_Locked is driven constant 1'b0. Consumers must then wait a fixed 4·WORD_DIV Bit_CLK cycles after reset instead.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use WORD_DIV=10.

1. Reset, DataBusWidth=8, release Rst_n -> Word_CLK and PCLK both rise at edge 1 with identical waveforms: period 10, high 5. Clk_Locked=1 at edge 11.
2. DataBusWidth=16 from reset -> PCLK period 20, high 10. Word_CLK period 10. Every PCLK rise coincides with a Word_CLK rise. Clk_Locked at edge 21.
3. DataBusWidth=32 from reset -> PCLK period 40, high 20. Clk_Locked at edge 41.
4. Running at width 8, switch to 32 at word_cnt=3 -> the current 10-cycle PCLK period completes unchanged, then 40-cycle periods follow. No PCLK high or low pulse is shorter than 5 edges. Clk_Locked is 0 at the boundary and 1 forty edges later. Without CLKGEN_LOCK_EN, Clk_Locked stays 0 throughout.
5. DataBusWidth=12 for 30 cycles while at width 16 -> Width_Err is 1 from one edge after the change until one edge after the width returns to 16. PCLK keeps its 20-cycle period. Clk_Locked stays 1.
6. Assert Rst_n while PCLK is high mid-period at width 32 -> Word_CLK, PCLK and Clk_Locked go to 0 asynchronously. After release, the sequence restarts as in scenario 3.
